// File: rtl/lsu_pkg.sv
// Shared load-unit definitions: widths, RV32I load encodings, FSM states.
package lsu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned REGW = 5;
   localparam int unsigned F3W  = 3;

   localparam logic [F3W-1:0] F3_LB  = 3'b000;
   localparam logic [F3W-1:0] F3_LH  = 3'b001;
   localparam logic [F3W-1:0] F3_LW  = 3'b010;
   localparam logic [F3W-1:0] F3_LBU = 3'b100;
   localparam logic [F3W-1:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      WB   = 2'd3
   } lsu_state_e;

   // High when a load cannot be issued: unknown funct3 or unaligned access.
   function automatic logic ld_reject(input logic [F3W-1:0] funct3, input logic [1:0] offset);
      logic bad;
      case (funct3)
         F3_LB, F3_LBU: bad = 1'b0;
         F3_LH, F3_LHU: bad = offset[0];
         F3_LW:         bad = (offset != 2'b00);
         default:       bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_wb_if.sv
// Data-memory read bus between the load unit (master) and memory (slave).
interface load_wb_if;
   import lsu_pkg::*;

   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_align.sv
// Selects and extends the addressed byte/halfword from a fetched word.
module load_align
   import lsu_pkg::*;
(
   input  logic [F3W-1:0]  funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select, then sign/zero extension by load type.
   always_comb begin
      byte_sel = word[7:0];
      half_sel = word[15:0];
      data     = word;
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      if (offset[1]) begin
         half_sel = word[31:16];
      end
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {24'd0, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data = {16'd0, half_sel};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/load_wb.sv
// Load unit: issues one word read per load, aligns the result and arbitrates
// the register-file write port against the ALU writeback.
module load_wb
   import lsu_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            ld_valid_i,
   output logic            ld_ready_o,
   input  logic [F3W-1:0]  ld_funct3_i,
   input  logic [XLEN-1:0] ld_addr_i,
   input  logic [REGW-1:0] ld_rd_i,
   input  logic            alu_wren_i,
   input  logic [REGW-1:0] alu_rd_i,
   input  logic [XLEN-1:0] alu_data_i,
   output logic            alu_stall_o,
   output logic            dmem_req_o,
   output logic [XLEN-1:0] dmem_addr_o,
   input  logic            dmem_gnt_i,
   input  logic            dmem_rvalid_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic            rd_wren_o,
   output logic [REGW-1:0] rd_addr_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic            misalign_o,
   output logic            busy_o
);

   lsu_state_e      state_q, state_d;
   logic [F3W-1:0]  funct3_q;
   logic [1:0]      off_q;
   logic [REGW-1:0] rd_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] data_q;
   logic            misalign_q;
   logic            accept;
   logic            reject;
   logic [XLEN-1:0] align_data;

   assign accept = ld_valid_i & (state_q == IDLE);
   assign reject = ld_reject(ld_funct3_i, ld_addr_i[1:0]);

   load_align u_align (
      .funct3 (funct3_q),
      .offset (off_q),
      .word   (dmem_rdata_i),
      .data   (align_data)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, bus/handshake outputs and register-file port mux.
   always_comb begin
      state_d     = state_q;
      ld_ready_o  = 1'b0;
      dmem_req_o  = 1'b0;
      busy_o      = 1'b1;
      alu_stall_o = 1'b0;
      rd_wren_o   = alu_wren_i & (alu_rd_i != '0);
      rd_addr_o   = alu_rd_i;
      rd_data_o   = alu_data_i;
      case (state_q)
         IDLE: begin
            ld_ready_o = 1'b1;
            busy_o     = 1'b0;
            if (ld_valid_i && !reject) begin
               state_d = REQ;
            end
         end
         REQ: begin
            dmem_req_o = 1'b1;
            if (dmem_gnt_i) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (dmem_rvalid_i) begin
               state_d = WB;
            end
         end
         WB: begin
            rd_wren_o   = (rd_q != '0);
            rd_addr_o   = rd_q;
            rd_data_o   = data_q;
            alu_stall_o = alu_wren_i;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture, reject pulse and aligned read-data capture.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         funct3_q   <= '0;
         off_q      <= '0;
         rd_q       <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= accept & reject;
         if (accept) begin
            funct3_q <= ld_funct3_i;
            off_q    <= ld_addr_i[1:0];
            rd_q     <= ld_rd_i;
            addr_q   <= {ld_addr_i[XLEN-1:2], 2'b00};
         end
         if ((state_q == WAIT) && dmem_rvalid_i) begin
            data_q <= align_data;
         end
      end
   end

   assign dmem_addr_o = addr_q;
   assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_load_wb.sv
// Self-checking bench for load_wb: directed scenarios plus randomized loads
// checked against an arithmetic reference of the load rules.
module tb_load_wb;

   logic        clk;
   logic        rst;
   logic        ld_valid;
   logic        ld_ready;
   logic [2:0]  ld_funct3;
   logic [31:0] ld_addr;
   logic [4:0]  ld_rd;
   logic        alu_wren;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        rd_wren;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        misalign;
   logic        busy;

   int vectors;
   int miscompares;

   load_wb_if mif ();

   load_wb dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .ld_valid_i    (ld_valid),
      .ld_ready_o    (ld_ready),
      .ld_funct3_i   (ld_funct3),
      .ld_addr_i     (ld_addr),
      .ld_rd_i       (ld_rd),
      .alu_wren_i    (alu_wren),
      .alu_rd_i      (alu_rd),
      .alu_data_i    (alu_data),
      .alu_stall_o   (alu_stall),
      .dmem_req_o    (mif.req),
      .dmem_addr_o   (mif.addr),
      .dmem_gnt_i    (mif.gnt),
      .dmem_rvalid_i (mif.rvalid),
      .dmem_rdata_i  (mif.rdata),
      .rd_wren_o     (rd_wren),
      .rd_addr_o     (rd_addr),
      .rd_data_o     (rd_data),
      .misalign_o    (misalign),
      .busy_o        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: {rejected, loaded value} from the RV32I load rules.
   function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
      int unsigned off, b, h, r;
      logic bad;
      off = addr % 4;
      b   = (word >> (8 * off)) & 32'hFF;
      h   = (word >> (16 * (off / 2))) & 32'hFFFF;
      r   = word;
      bad = 1'b0;
      case (f3)
         3'd0: r = (b >= 128) ? b - 256 : b;
         3'd4: r = b;
         3'd1: begin r = (h >= 32768) ? h - 65536 : h; bad = (off % 2) != 0; end
         3'd5: begin r = h; bad = (off % 2) != 0; end
         3'd2: begin r = word; bad = off != 0; end
         default: bad = 1'b1;
      endcase
      return {bad, 32'(r)};
   endfunction

   // Idle-state expectations with ALU-only register writes.
   task automatic check_idle(input string tag);
      check({tag, "_ready"}, 32'(ld_ready), 1);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_req"}, 32'(mif.req), 0);
      check({tag, "_stall"}, 32'(alu_stall), 0);
      check({tag, "_wren"}, 32'(rd_wren), 32'(alu_wren && (alu_rd != 0)));
      check({tag, "_waddr"}, 32'(rd_addr), 32'(alu_rd));
      check({tag, "_wdata"}, rd_data, alu_data);
   endtask

   // One complete load; called and returning at a negedge.
   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] word, input int gdly, input int rdly,
                          input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                          input logic junk);
      logic [32:0] m;
      logic [31:0] wa;
      m  = ref_load(f3, addr, word);
      wa = addr & 32'hFFFF_FFFC;
      alu_wren  = 1'b0;
      ld_valid  = 1'b1;
      ld_funct3 = f3;
      ld_addr   = addr;
      ld_rd     = rd;
      #1;
      check("accept_ready", 32'(ld_ready), 1);
      @(posedge clk);
      @(negedge clk);
      ld_valid = 1'b0;
      ld_addr  = $urandom;
      ld_rd    = 5'($urandom);
      if (m[32]) begin
         alu_wren = aw; alu_rd = ar; alu_data = ad;
         #1;
         check("rej_pulse", 32'(misalign), 1);
         check_idle("rej");
         @(posedge clk);
         @(negedge clk);
         check("rej_pulse_end", 32'(misalign), 0);
         check("rej_noreq", 32'(mif.req), 0);
         alu_wren = 1'b0;
         return;
      end
      check("ok_nopulse", 32'(misalign), 0);
      for (int i = 0; i < gdly; i++) begin
         mif.gnt = 1'b0; mif.rvalid = junk; mif.rdata = $urandom;
         #1;
         check("req_hold", 32'(mif.req), 1);
         check("req_addr_hold", mif.addr, wa);
         check("req_notready", 32'(ld_ready), 0);
         @(posedge clk);
         @(negedge clk);
      end
      mif.rvalid = 1'b0; mif.gnt = 1'b1;
      #1;
      check("req", 32'(mif.req), 1);
      check("req_addr", mif.addr, wa);
      check("req_busy", 32'(busy), 1);
      @(posedge clk);
      @(negedge clk);
      mif.gnt = 1'b0;
      for (int i = 0; i < rdly; i++) begin
         #1;
         check("wait_noreq", 32'(mif.req), 0);
         check("wait_busy", 32'(busy), 1);
         check("wait_nowr", 32'(rd_wren), 0);
         @(posedge clk);
         @(negedge clk);
      end
      mif.rvalid = 1'b1; mif.rdata = word;
      @(posedge clk);
      @(negedge clk);
      mif.rvalid = 1'b0; mif.rdata = $urandom;
      alu_wren = aw; alu_rd = ar; alu_data = ad;
      #1;
      check("wb_wren", 32'(rd_wren), 32'(rd != 0));
      check("wb_waddr", 32'(rd_addr), 32'(rd));
      check("wb_wdata", rd_data, m[31:0]);
      check("wb_stall", 32'(alu_stall), 32'(aw));
      check("wb_busy", 32'(busy), 1);
      check("wb_noreq", 32'(mif.req), 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check_idle("post_wb");
      alu_wren = 1'b0;
   endtask

   initial begin
      logic [2:0]  valid_f3 [5];
      logic [2:0]  f3;
      logic [31:0] addr;
      vectors     = 0;
      miscompares = 0;
      valid_f3    = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      rst = 1'b1; ld_valid = 1'b0; ld_funct3 = '0; ld_addr = '0; ld_rd = '0;
      alu_wren = 1'b0; alu_rd = '0; alu_data = '0;
      mif.gnt = 1'b0; mif.rvalid = 1'b0; mif.rdata = '0;

      // Reset values, while reset is still asserted.
      repeat (2) @(posedge clk);
      @(negedge clk);
      alu_wren = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE_0009;
      #1;
      check_idle("reset");
      check("reset_misalign", 32'(misalign), 0);
      rst = 1'b0; alu_wren = 1'b0;
      @(negedge clk);

      // Directed scenarios.
      do_load(3'd0, 32'h0000_1003, 5'd5, 32'h80FF_1234, 0, 0, 1'b0, 5'd0, 32'd0, 1'b0);
      do_load(3'd5, 32'h0000_2002, 5'd7, 32'hBEEF_0001, 2, 0, 1'b0, 5'd0, 32'd0, 1'b1);
      do_load(3'd2, 32'h0000_3001, 5'd8, 32'h0, 0, 0, 1'b1, 5'd11, 32'h1111_2222, 1'b0);
      do_load(3'd2, 32'h0000_3004, 5'd0, 32'h1234_5678, 0, 1, 1'b0, 5'd0, 32'd0, 1'b0);
      do_load(3'd2, 32'h0000_3008, 5'd3, 32'hA5A5_5A5A, 1, 0, 1'b1, 5'd4, 32'h0404_0404, 1'b0);

      // Reset while waiting for read data; a late response must be dropped.
      ld_valid = 1'b1; ld_funct3 = 3'd2; ld_addr = 32'h0000_4000; ld_rd = 5'd9;
      @(posedge clk);
      @(negedge clk);
      ld_valid = 1'b0; mif.gnt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mif.gnt = 1'b0; rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check_idle("rst_wait");
      check("rst_wait_misalign", 32'(misalign), 0);
      rst = 1'b0; mif.rvalid = 1'b1; mif.rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      #1;
      check_idle("late_rvalid");
      mif.rvalid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check_idle("late_rvalid2");

      // Randomized loads with random memory timing and ALU traffic.
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
         else f3 = valid_f3[$urandom_range(0, 4)];
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            if (f3 == 3'd2) addr = addr & 32'hFFFF_FFFC;
            else if (f3 == 3'd1 || f3 == 3'd5) addr = addr & 32'hFFFF_FFFE;
         end
         do_load(f3, addr, 5'($urandom), $urandom, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom), 5'($urandom), $urandom, 1'($urandom));
         repeat ($urandom_range(0, 2)) begin
            alu_wren = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
            #1;
            check_idle("gap");
            @(posedge clk);
            @(negedge clk);
         end
         alu_wren = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
